// File: rtl/mig_sched_pkg.sv
// Shared types and MIG constants for the p0 burst scheduler.
package mig_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_FILL,
        ST_WR_CMD,
        ST_RD_CMD,
        ST_RD_DRAIN
    } state_e;

    typedef enum logic {
        GRANT_WR,
        GRANT_RD
    } grant_e;

    localparam logic [2:0]  MIG_INSTR_WR      = 3'b000;
    localparam logic [2:0]  MIG_INSTR_RD      = 3'b001;
    localparam int unsigned MIG_WR_FIFO_DEPTH = 64;
    localparam int unsigned MIG_BL_W          = 6;
    localparam int unsigned MIG_WR_CNT_W      = 7;
    localparam int unsigned MIG_DATA_W        = 32;
    localparam int unsigned WORD_CNT_W        = 7;

endpackage

// File: rtl/mig_addr_ptr.sv
// Linear byte-address pointer that steps by one burst and wraps to 0 at LIMIT.
module mig_addr_ptr #(
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned STEP       = 128,
    parameter int unsigned LIMIT      = 32'h0800_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  adv,
    output logic [ADDR_WIDTH-1:0] addr
);

    localparam int unsigned SUM_W = ADDR_WIDTH + 1;

    // One spare bit so the step can never silently overflow past the limit.
    logic [SUM_W-1:0] sum_c;
    assign sum_c = {1'b0, addr} + SUM_W'(STEP);

    always_ff @(posedge clk) begin
        if (reset) begin
            addr <= '0;
        end else if (adv) begin
            addr <= (sum_c >= SUM_W'(LIMIT)) ? '0 : sum_c[ADDR_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mig_burst_scheduler.sv
// Round-robin burst scheduler between the PipeIn/PipeOut FIFOs and MIG port p0.
// Optional burst statistics counters: define MIG_BURST_STATS_EN.
module mig_burst_scheduler
    import mig_sched_pkg::*;
#(
    parameter int unsigned BURST_LEN  = 32,
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned ADDR_LIMIT = 32'h0800_0000,
    parameter int unsigned OB_DEPTH   = 1024,
    parameter int unsigned CNT_W      = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    calib_done,
    input  logic                    writes_en,
    input  logic                    reads_en,
    input  logic [CNT_W-1:0]        ib_count,
    output logic                    ib_re,
    input  logic [MIG_DATA_W-1:0]   ib_data,
    input  logic                    ib_valid,
    input  logic [CNT_W-1:0]        ob_count,
    output logic                    ob_we,
    output logic [MIG_DATA_W-1:0]   ob_data,
    output logic                    p0_cmd_en,
    output logic [2:0]              p0_cmd_instr,
    output logic [MIG_BL_W-1:0]     p0_cmd_bl,
    output logic [ADDR_WIDTH-1:0]   p0_cmd_byte_addr,
    input  logic                    p0_cmd_full,
    output logic                    p0_wr_en,
    output logic [MIG_DATA_W-1:0]   p0_wr_data,
    input  logic [MIG_WR_CNT_W-1:0] p0_wr_count,
    output logic                    p0_rd_en,
    input  logic [MIG_DATA_W-1:0]   p0_rd_data,
    input  logic                    p0_rd_empty,
    output logic [31:0]             burst_wr_cnt,
    output logic [31:0]             burst_rd_cnt
);

    localparam logic [WORD_CNT_W-1:0] BURST_WORDS = WORD_CNT_W'(BURST_LEN);
    localparam logic [WORD_CNT_W-1:0] LAST_WORD   = WORD_CNT_W'(BURST_LEN - 1);

    state_e                  state_q, state_d;
    grant_e                  last_grant;
    logic [WORD_CNT_W-1:0]   word_cnt;
    logic [WORD_CNT_W-1:0]   re_cnt;
    logic [ADDR_WIDTH-1:0]   wr_addr, rd_addr;
    logic                    wr_adv, rd_adv;
    logic                    wr_ok, rd_ok;

    assign wr_ok = writes_en
                 && (ib_count >= CNT_W'(BURST_LEN))
                 && (p0_wr_count <= MIG_WR_CNT_W'(MIG_WR_FIFO_DEPTH - BURST_LEN));
    assign rd_ok = reads_en && (ob_count <= CNT_W'(OB_DEPTH - BURST_LEN));

    assign p0_cmd_bl = MIG_BL_W'(BURST_LEN - 1);
    // Read data goes straight from the fall-through MIG FIFO into PipeOut.
    assign ob_we   = p0_rd_en;
    assign ob_data = p0_rd_data;

    // Next state; FIFO/command strobes are handshake-qualified in the same cycle.
    always_comb begin
        state_d          = state_q;
        ib_re            = 1'b0;
        p0_cmd_en        = 1'b0;
        p0_cmd_instr     = MIG_INSTR_WR;
        p0_cmd_byte_addr = '0;
        p0_rd_en         = 1'b0;
        wr_adv           = 1'b0;
        rd_adv           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (calib_done && !p0_cmd_full) begin
                    if (wr_ok && (!rd_ok || last_grant == GRANT_RD)) begin
                        state_d = ST_WR_FILL;
                    end else if (rd_ok) begin
                        state_d = ST_RD_CMD;
                    end
                end
            end
            ST_WR_FILL: begin
                ib_re = (re_cnt < BURST_WORDS);
                if (p0_wr_en && word_cnt == LAST_WORD) begin
                    state_d = ST_WR_CMD;
                end
            end
            ST_WR_CMD: begin
                p0_cmd_byte_addr = wr_addr;
                if (!p0_cmd_full) begin
                    p0_cmd_en = 1'b1;
                    wr_adv    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_RD_CMD: begin
                p0_cmd_instr     = MIG_INSTR_RD;
                p0_cmd_byte_addr = rd_addr;
                if (!p0_cmd_full) begin
                    p0_cmd_en = 1'b1;
                    rd_adv    = 1'b1;
                    state_d   = ST_RD_DRAIN;
                end
            end
            ST_RD_DRAIN: begin
                p0_rd_en = !p0_rd_empty;
                if (p0_rd_en && word_cnt == LAST_WORD) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_grant <= GRANT_RD;
            word_cnt   <= '0;
            re_cnt     <= '0;
            p0_wr_en   <= 1'b0;
            p0_wr_data <= '0;
        end else begin
            state_q    <= state_d;
            p0_wr_en   <= (state_q == ST_WR_FILL) && ib_valid;
            p0_wr_data <= ib_data;
            re_cnt     <= (state_q == ST_WR_FILL) ? re_cnt + WORD_CNT_W'(ib_re) : '0;
            // Counts words landed in p0 (write) or popped from p0 (read) this burst.
            if (state_d != state_q) begin
                word_cnt <= '0;
            end else if (p0_rd_en || (state_q == ST_WR_FILL && p0_wr_en)) begin
                word_cnt <= word_cnt + WORD_CNT_W'(1);
            end
            if (wr_adv) begin
                last_grant <= GRANT_WR;
            end else if (rd_adv) begin
                last_grant <= GRANT_RD;
            end
        end
    end

    mig_addr_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STEP       (4 * BURST_LEN),
        .LIMIT      (ADDR_LIMIT)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .adv   (wr_adv),
        .addr  (wr_addr)
    );

    mig_addr_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .STEP       (4 * BURST_LEN),
        .LIMIT      (ADDR_LIMIT)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .adv   (rd_adv),
        .addr  (rd_addr)
    );

`ifdef MIG_BURST_STATS_EN
    logic [31:0] wr_bursts_q, rd_bursts_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bursts_q <= '0;
            rd_bursts_q <= '0;
        end else begin
            if (wr_adv) wr_bursts_q <= wr_bursts_q + 32'd1;
            if (rd_adv) rd_bursts_q <= rd_bursts_q + 32'd1;
        end
    end

    assign burst_wr_cnt = wr_bursts_q;
    assign burst_rd_cnt = rd_bursts_q;
`else
    assign burst_wr_cnt = '0;
    assign burst_rd_cnt = '0;
`endif

endmodule

// File: tb/tb_mig_burst_scheduler.sv
// Self-checking bench for mig_burst_scheduler with PipeIn/MIG read models and scoreboards.
module tb_mig_burst_scheduler;

    localparam int unsigned BURST_LEN  = 32;
    localparam int unsigned ADDR_WIDTH = 30;
    localparam int unsigned ADDR_LIMIT = 32'h180;
    localparam int unsigned STEP       = 4 * BURST_LEN;
    localparam int unsigned RD_LAT     = 3;
    localparam logic [1:0]  C_NONE     = 2'd0;
    localparam logic [1:0]  C_WR       = 2'd1;
    localparam logic [1:0]  C_RD       = 2'd2;

    logic                  clk;
    logic                  reset;
    logic                  calib_done;
    logic                  writes_en;
    logic                  reads_en;
    logic [9:0]            ib_count;
    logic                  ib_re;
    logic [31:0]           ib_data;
    logic                  ib_valid;
    logic [9:0]            ob_count;
    logic                  ob_we;
    logic [31:0]           ob_data;
    logic                  p0_cmd_en;
    logic [2:0]            p0_cmd_instr;
    logic [5:0]            p0_cmd_bl;
    logic [ADDR_WIDTH-1:0] p0_cmd_byte_addr;
    logic                  p0_cmd_full;
    logic                  p0_wr_en;
    logic [31:0]           p0_wr_data;
    logic [6:0]            p0_wr_count;
    logic                  p0_rd_en;
    logic [31:0]           p0_rd_data;
    logic                  p0_rd_empty;
    logic [31:0]           burst_wr_cnt;
    logic [31:0]           burst_rd_cnt;

    mig_burst_scheduler #(
        .BURST_LEN  (BURST_LEN),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR_LIMIT (ADDR_LIMIT),
        .OB_DEPTH   (1024),
        .CNT_W      (10)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .calib_done       (calib_done),
        .writes_en        (writes_en),
        .reads_en         (reads_en),
        .ib_count         (ib_count),
        .ib_re            (ib_re),
        .ib_data          (ib_data),
        .ib_valid         (ib_valid),
        .ob_count         (ob_count),
        .ob_we            (ob_we),
        .ob_data          (ob_data),
        .p0_cmd_en        (p0_cmd_en),
        .p0_cmd_instr     (p0_cmd_instr),
        .p0_cmd_bl        (p0_cmd_bl),
        .p0_cmd_byte_addr (p0_cmd_byte_addr),
        .p0_cmd_full      (p0_cmd_full),
        .p0_wr_en         (p0_wr_en),
        .p0_wr_data       (p0_wr_data),
        .p0_wr_count      (p0_wr_count),
        .p0_rd_en         (p0_rd_en),
        .p0_rd_data       (p0_rd_data),
        .p0_rd_empty      (p0_rd_empty),
        .burst_wr_cnt     (burst_wr_cnt),
        .burst_rd_cnt     (burst_rd_cnt)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0]           exp_wr_q[$];
    logic [31:0]           exp_ob_q[$];
    logic [31:0]           mig_rdq[$];
    logic [2:0]            cmd_log[$];
    int                    cmd_cnt  = 0;
    int                    rd_seen  = 0;
    int                    rd_served = 0;
    int                    rd_lat   = 0;
    logic [31:0]           ib_seq   = 32'hC0DE_0000;
    logic [31:0]           rd_word  = 32'h5A00_0001;
    logic [ADDR_WIDTH-1:0] exp_wr_addr = '0;
    logic [ADDR_WIDTH-1:0] exp_rd_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH:0] s;
        s = {1'b0, a} + (ADDR_WIDTH+1)'(STEP);
        return (s >= (ADDR_WIDTH+1)'(ADDR_LIMIT)) ? '0 : s[ADDR_WIDTH-1:0];
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PipeIn FIFO model: data one cycle after the read strobe.
    always @(posedge clk) begin
        ib_valid <= ib_re;
        if (ib_re === 1'b1) begin
            ib_data <= ib_seq;
            exp_wr_q.push_back(ib_seq);
            ib_seq = ib_seq + 32'd1;
        end
    end

    // MIG read path model: a full burst appears RD_LAT cycles after each read command.
    always @(posedge clk) begin
        if (p0_rd_en === 1'b1 && mig_rdq.size() > 0) void'(mig_rdq.pop_front());
        if (rd_served != rd_seen) begin
            if (rd_lat == RD_LAT) begin
                for (int k = 0; k < BURST_LEN; k++) begin
                    mig_rdq.push_back(rd_word);
                    exp_ob_q.push_back(rd_word);
                    rd_word = rd_word + 32'h1357_9BDF;
                end
                rd_served++;
                rd_lat = 0;
            end else begin
                rd_lat++;
            end
        end
        p0_rd_empty <= (mig_rdq.size() == 0);
        p0_rd_data  <= (mig_rdq.size() > 0) ? mig_rdq[0] : 32'h0;
    end

    // Output monitor on the falling edge.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (p0_wr_en === 1'b1) begin
                check("wr_q_nonempty", 64'(exp_wr_q.size() > 0), 64'd1);
                if (exp_wr_q.size() > 0) check("wr_data", 64'(p0_wr_data), 64'(exp_wr_q.pop_front()));
            end
            if (ob_we === 1'b1) begin
                check("ob_q_nonempty", 64'(exp_ob_q.size() > 0), 64'd1);
                if (exp_ob_q.size() > 0) check("ob_data", 64'(ob_data), 64'(exp_ob_q.pop_front()));
            end
            if (p0_cmd_en === 1'b1 && p0_cmd_full === 1'b0) begin
                cmd_log.push_back(p0_cmd_instr);
                cmd_cnt++;
                check("cmd_bl", 64'(p0_cmd_bl), 64'(BURST_LEN - 1));
                if (p0_cmd_instr == 3'b000) begin
                    check("wr_cmd_addr", 64'(p0_cmd_byte_addr), 64'(exp_wr_addr));
                    exp_wr_addr = next_addr(exp_wr_addr);
                end else begin
                    check("rd_cmd_instr", 64'(p0_cmd_instr), 64'h1);
                    check("rd_cmd_addr", 64'(p0_cmd_byte_addr), 64'(exp_rd_addr));
                    exp_rd_addr = next_addr(exp_rd_addr);
                    rd_seen++;
                end
            end
        end
    end

    typedef struct {
        logic       calib;
        logic       wen;
        logic       ren;
        logic       full;
        logic [9:0] ib;
        logic [9:0] ob;
        logic [6:0] wrc;
        logic [1:0] exp;
    } vec_t;

    vec_t        vecs[13];
    logic [1:0]  got;
    logic [2:0]  seen;
    logic [2:0]  alt_exp[4];
    logic [31:0] exp_stats_wr;
    int          c0;
    int          n;
    int          nf;

    initial begin
        reset       = 1'b1;
        calib_done  = 1'b0;
        writes_en   = 1'b0;
        reads_en    = 1'b0;
        ib_count    = '0;
        ob_count    = '0;
        p0_cmd_full = 1'b0;
        p0_wr_count = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_strobes", 64'({ib_re, p0_wr_en, p0_cmd_en, p0_rd_en, ob_we}), 64'd0);
        check("reset_stats_wr", 64'(burst_wr_cnt), 64'd0);
        check("reset_stats_rd", 64'(burst_rd_cnt), 64'd0);
        reset      = 1'b0;
        calib_done = 1'b1;

        //          calib  wen   ren   full  ib      ob       wrc    expected
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 10'd32, 10'd0,   7'd0,  C_NONE};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd31, 10'd0,   7'd0,  C_NONE};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd32, 10'd0,   7'd33, C_NONE};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd32, 10'd0,   7'd32, C_WR};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd0,  10'd993, 7'd0,  C_NONE};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd0,  10'd992, 7'd0,  C_RD};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 10'd32, 10'd0,   7'd0,  C_NONE};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10'd32, 10'd0,   7'd0,  C_WR};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 10'd32, 10'd0,   7'd0,  C_RD};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd40, 10'd0,   7'd0,  C_WR};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 10'd32, 10'd0,   7'd0,  C_WR};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 10'd32, 10'd0,   7'd0,  C_RD};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 10'd0,  10'd0,   7'd0,  C_RD};

        for (int i = 0; i < 13; i++) begin
            calib_done  = vecs[i].calib;
            writes_en   = vecs[i].wen;
            reads_en    = vecs[i].ren;
            p0_cmd_full = vecs[i].full;
            ib_count    = vecs[i].ib;
            ob_count    = vecs[i].ob;
            p0_wr_count = vecs[i].wrc;
            c0  = cmd_cnt;
            got = C_NONE;
            for (int t = 0; t < 80; t++) begin
                @(posedge clk);
                #1;
                if (cmd_cnt != c0) begin
                    got = (cmd_log[c0] == 3'b000) ? C_WR : C_RD;
                    break;
                end
            end
            writes_en   = 1'b0;
            reads_en    = 1'b0;
            p0_cmd_full = 1'b0;
            calib_done  = 1'b1;
            check($sformatf("vec%0d_grant", i), 64'(got), 64'(vecs[i].exp));
            repeat (60) @(posedge clk);
            #1;
        end

        // Alternation from reset: W,R,W,R.
        reset = 1'b1;
        exp_wr_addr = '0;
        exp_rd_addr = '0;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        writes_en   = 1'b1;
        reads_en    = 1'b1;
        ib_count    = 10'd32;
        ob_count    = 10'd0;
        p0_wr_count = 7'd0;
        c0 = cmd_cnt;
        for (int t = 0; t < 600; t++) begin
            @(posedge clk);
            #1;
            if (cmd_cnt >= c0 + 4) break;
        end
        writes_en = 1'b0;
        reads_en  = 1'b0;
        check("alt_cmds", 64'(cmd_cnt - c0), 64'd4);
        alt_exp[0] = 3'b000;
        alt_exp[1] = 3'b001;
        alt_exp[2] = 3'b000;
        alt_exp[3] = 3'b001;
        for (int i = 0; i < 4; i++) begin
            seen = (c0 + i < cmd_log.size()) ? cmd_log[c0 + i] : 3'b111;
            check($sformatf("alt_grant%0d", i), 64'(seen), 64'(alt_exp[i]));
        end
        repeat (60) @(posedge clk);
        #1;

        // Reset at word 10 of a write fill.
        writes_en = 1'b1;
        ib_count  = 10'd32;
        n = 0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            #1;
            if (ib_re === 1'b1) n++;
            if (n == 10) break;
        end
        reset       = 1'b1;
        writes_en   = 1'b0;
        exp_wr_addr = '0;
        exp_rd_addr = '0;
        @(posedge clk);
        #1;
        check("rst_mid_strobes", 64'({ib_re, p0_wr_en, p0_cmd_en, p0_rd_en, ob_we}), 64'd0);
        check("rst_mid_re_count", 64'(n), 64'd10);
        reset = 1'b0;
        c0 = cmd_cnt;
        repeat (3) @(posedge clk);
        #1;
        exp_wr_q.delete();
        repeat (40) @(posedge clk);
        #1;
        check("rst_mid_no_cmd", 64'(cmd_cnt - c0), 64'd0);
        check("rst_mid_idle", 64'({ib_re, p0_wr_en}), 64'd0);

        // Command FIFO full for 5 cycles while the write command is pending.
        writes_en = 1'b1;
        ib_count  = 10'd32;
        n = 0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            #1;
            if (p0_wr_en === 1'b1) n++;
            if (n == BURST_LEN) break;
        end
        p0_cmd_full = 1'b1;
        nf = 0;
        c0 = cmd_cnt;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (p0_cmd_en === 1'b1) nf++;
        end
        check("full_hold_cmd", 64'(nf), 64'd0);
        p0_cmd_full = 1'b0;
        writes_en   = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("full_release_cmds", 64'(cmd_cnt - c0), 64'd1);
        seen = (c0 < cmd_log.size()) ? cmd_log[c0] : 3'b111;
        check("full_release_instr", 64'(seen), 64'd0);
`ifdef MIG_BURST_STATS_EN
        exp_stats_wr = 32'd1;
`else
        exp_stats_wr = 32'd0;
`endif
        check("stats_wr", 64'(burst_wr_cnt), 64'(exp_stats_wr));
        check("stats_rd", 64'(burst_rd_cnt), 64'd0);

        repeat (20) @(posedge clk);
        #1;
        check("end_wr_q_empty", 64'(exp_wr_q.size()), 64'd0);
        check("end_ob_q_empty", 64'(exp_ob_q.size()), 64'd0);
        check("end_rd_served", 64'(rd_served), 64'(rd_seen));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
